// File: rtl/zap_mult_ctrl_pkg.sv
// Shared types for the multiply-unit controller.
//   AluOps / Opw : opcode space and opcode width
//   state_e      : controller sequencing states
//   req_t        : one latched multiply request (opcodes, length flag, operands)
package zap_mult_ctrl_pkg;

  localparam int unsigned AluOps = 32;
  localparam int unsigned Opw    = $clog2(AluOps);

  typedef enum logic [2:0] {
    StIdle,
    StIssueLo,
    StWaitLo,
    StIssueHi,
    StWaitHi,
    StResp
  } state_e;

  typedef struct packed {
    logic [Opw-1:0] op_lo;
    logic [Opw-1:0] op_hi;
    logic           is_long;
    logic [31:0]    rm;
    logic [31:0]    rs;
    logic [31:0]    rn;
    logic [31:0]    rh;
  } req_t;

endpackage

// File: rtl/zap_mult_ctrl_if.sv
// Request/response bus between the two requesters and the multiply controller.
//   req_valid/req_ready : per-port request handshake (index 0 = pipeline, 1 = coprocessor)
//   req                 : per-port request payload
//   rsp_*               : single response channel back to the requesters
// master = requester side, slave = controller side.
interface zap_mult_ctrl_if;
  import zap_mult_ctrl_pkg::*;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  req_t [1:0]       req;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [31:0]      rsp_lo;
  logic [31:0]      rsp_hi;
  logic             rsp_sat;
  logic             rsp_nozero;

  modport master (
    output req_valid, req, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_sat, rsp_nozero
  );

  modport slave (
    input  req_valid, req, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_sat, rsp_nozero
  );

endinterface

// File: rtl/zap_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk_i, reset_i : clock, synchronous active-high reset (pointer -> port 0)
//   req_i          : request vector
//   advance_i      : accept strobe; pointer flips only when both ports were contending
//   gnt_o          : one-hot grant (zero when nothing requests)
module zap_rr_arbiter2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (&req_i)) ptr_d = ~ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/zap_mult_ctrl.sv
// Controller and 2-way arbiter in front of the shared multi-cycle multiplier.
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_clear             : flush in-flight op (no response); forwarded as o_m_clear
//   i_stall             : freeze controller; forwarded as o_m_stall
//   bus                 : request/response handshakes (slave side)
//   o_m_*               : multiplier opcode, operands, go, stall, clear
//   i_m_*               : multiplier busy, result and flags
// 64-bit ops run as a low pass then a high pass; one response carries both halves.
module zap_mult_ctrl
  import zap_mult_ctrl_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_clear,
  input  logic            i_stall,
  zap_mult_ctrl_if.slave  bus,
  output logic [Opw-1:0]  o_m_op,
  output logic [31:0]     o_m_rm,
  output logic [31:0]     o_m_rs,
  output logic [31:0]     o_m_rn,
  output logic [31:0]     o_m_rh,
  output logic            o_m_go,
  output logic            o_m_stall,
  output logic            o_m_clear,
  input  logic            i_m_busy,
  input  logic [31:0]     i_m_rd,
  input  logic            i_m_sat,
  input  logic            i_m_nozero
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        id_q, id_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        sat_q, sat_d;
  logic        nozero_q, nozero_d;

  logic [1:0]  gnt;
  logic        accept;
  logic        hi_pass;

  // Stall blocks accepts, so the pointer never moves while frozen.
  assign accept = (state_q == StIdle) && !i_stall && (|(bus.req_valid & gnt));

  zap_rr_arbiter2 u_arb (
    .clk_i     (i_clk),
    .reset_i   (i_reset),
    .req_i     (bus.req_valid),
    .advance_i (accept && !i_clear),
    .gnt_o     (gnt)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    id_d     = id_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    sat_d    = sat_q;
    nozero_d = nozero_q;
    if (i_clear) begin
      // Clear wins over stall and drops any accept in the same cycle.
      state_d  = StIdle;
      req_d    = '0;
      id_d     = 1'b0;
      lo_d     = '0;
      hi_d     = '0;
      sat_d    = 1'b0;
      nozero_d = 1'b0;
    end else if (!i_stall) begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            id_d     = gnt[1];
            req_d    = gnt[1] ? bus.req[1] : bus.req[0];
            lo_d     = '0;
            hi_d     = '0;
            sat_d    = 1'b0;
            nozero_d = 1'b0;
            state_d  = StIssueLo;
          end
        end
        StIssueLo: state_d = StWaitLo;
        StWaitLo: begin
          if (!i_m_busy) begin
            lo_d    = i_m_rd;
            sat_d   = i_m_sat;
            state_d = req_q.is_long ? StIssueHi : StResp;
          end
        end
        StIssueHi: state_d = StWaitHi;
        StWaitHi: begin
          if (!i_m_busy) begin
            hi_d     = i_m_rd;
            sat_d    = sat_q | i_m_sat;
            nozero_d = i_m_nozero;
            state_d  = StResp;
          end
        end
        StResp: begin
          if (bus.rsp_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      req_q    <= '0;
      id_q     <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      sat_q    <= 1'b0;
      nozero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      id_q     <= id_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      sat_q    <= sat_d;
      nozero_q <= nozero_d;
    end
  end

  // go must drop in RESP, otherwise the multiplier restarts on the held op.
  always_comb begin
    hi_pass = (state_q == StIssueHi) || (state_q == StWaitHi) ||
              ((state_q == StResp) && req_q.is_long);
    o_m_go  = (state_q == StIssueLo) || (state_q == StWaitLo) ||
              (state_q == StIssueHi) || (state_q == StWaitHi);
    o_m_op  = '0;
    o_m_rm  = '0;
    o_m_rs  = '0;
    o_m_rn  = '0;
    o_m_rh  = '0;
    if (state_q != StIdle) begin
      o_m_op = hi_pass ? req_q.op_hi : req_q.op_lo;
      o_m_rm = req_q.rm;
      o_m_rs = req_q.rs;
      o_m_rn = req_q.rn;
      o_m_rh = req_q.rh;
    end
  end

  assign o_m_stall      = i_stall;
  assign o_m_clear      = i_clear | i_reset;

  assign bus.req_ready  = ((state_q == StIdle) && !i_stall) ? gnt : 2'b00;
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_lo     = lo_q;
  assign bus.rsp_hi     = hi_q;
  assign bus.rsp_sat    = sat_q;
  assign bus.rsp_nozero = nozero_q;

endmodule

// File: tb/tb_zap_mult_ctrl.sv
module tb_zap_mult_ctrl;
  import zap_mult_ctrl_pkg::*;

  localparam logic [Opw-1:0] OpUmlall = Opw'(14);
  localparam logic [Opw-1:0] OpUmlalh = Opw'(15);

  typedef struct packed {
    logic        id;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        sat;
    logic        nozero;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst, clr, stall;
  logic [Opw-1:0] m_op;
  logic [31:0]    m_rm, m_rs, m_rn, m_rh, m_rd;
  logic           m_go, m_stall, m_clear, m_busy, m_sat, m_nozero;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];

  zap_mult_ctrl_if bus ();

  zap_mult_ctrl dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_clear    (clr),
    .i_stall    (stall),
    .bus        (bus),
    .o_m_op     (m_op),
    .o_m_rm     (m_rm),
    .o_m_rs     (m_rs),
    .o_m_rn     (m_rn),
    .o_m_rh     (m_rh),
    .o_m_go     (m_go),
    .o_m_stall  (m_stall),
    .o_m_clear  (m_clear),
    .i_m_busy   (m_busy),
    .i_m_rd     (m_rd),
    .i_m_sat    (m_sat),
    .i_m_nozero (m_nozero)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: low pass busy for 3 cycles from the go/op change,
  // high pass busy for 1 cycle; age freezes while stalled.
  logic           go_prev = 1'b0;
  logic [Opw-1:0] op_prev = '0;
  int unsigned    age = 0;
  int             go_rises = 0;
  logic           start;
  logic [63:0]    prod;

  assign start    = m_go && (!go_prev || (m_op != op_prev));
  assign prod     = ({32'b0, m_rm} * {32'b0, m_rs}) + {m_rh, m_rn};
  assign m_busy   = m_go && (start || (age < ((m_op == OpUmlalh) ? 32'd1 : 32'd3)));
  assign m_rd     = (m_op == OpUmlalh) ? prod[63:32] : prod[31:0];
  assign m_sat    = m_rn[31];
  assign m_nozero = (prod != 64'd0);

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    go_prev <= m_go;
    op_prev <= m_op;
    if (m_go && !go_prev) go_rises <= go_rises + 1;
    if (!m_go)       age <= 0;
    else if (start)  age <= 1;
    else if (!stall) age <= age + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic req_t mk(input logic [Opw-1:0] lo, input logic [Opw-1:0] hi,
                              input logic lg, input logic [31:0] rm, input logic [31:0] rs,
                              input logic [31:0] rn, input logic [31:0] rh);
    req_t r;
    r.op_lo = lo; r.op_hi = hi; r.is_long = lg;
    r.rm = rm; r.rs = rs; r.rn = rn; r.rh = rh;
    return r;
  endfunction

  function automatic logic [31:0] pass_res(input logic [Opw-1:0] op, input logic [63:0] p);
    return (op == OpUmlalh) ? p[63:32] : p[31:0];
  endfunction

  function automatic exp_t model(input logic id, input req_t r);
    logic [63:0] p;
    exp_t e;
    p        = ({32'b0, r.rm} * {32'b0, r.rs}) + {r.rh, r.rn};
    e.id     = id;
    e.lo     = pass_res(r.op_lo, p);
    e.hi     = r.is_long ? pass_res(r.op_hi, p) : 32'd0;
    e.sat    = r.rn[31];
    e.nozero = r.is_long ? (p != 64'd0) : 1'b0;
    return e;
  endfunction

  function automatic exp_t got_rsp();
    exp_t g;
    g = {bus.rsp_id, bus.rsp_lo, bus.rsp_hi, bus.rsp_sat, bus.rsp_nozero};
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a request; t is the cycle in which the handshake completes.
  task automatic send(input int p, input req_t r, output int t, output bit ok);
    ok = 1'b0;
    t  = -1;
    bus.req[p]       = r;
    bus.req_valid[p] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.req_ready[p]) begin
        t  = cyc;
        ok = 1'b1;
        sb.push_back(model(p[0], r));
        tick();
        break;
      end
      tick();
    end
    bus.req_valid[p] = 1'b0;
  endtask

  task automatic wait_rsp(output int t, output bit ok);
    ok = 1'b0;
    t  = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.rsp_valid) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; stall = 1'b0;
    bus.req_valid = 2'b00; bus.req = '0; bus.rsp_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (m_clear !== 1'b1) begin
      n_fail++; $display("FAIL reset_m_clear_during: got %b want 1", m_clear);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (m_clear !== 1'b0) begin
      n_fail++; $display("FAIL reset_m_clear: got %b want 0", m_clear);
    end
    n_checks++;
    if ({bus.rsp_valid, bus.req_ready, m_go, m_stall} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rsp_valid=%b ready=%b go=%b stall=%b want all 0",
               bus.rsp_valid, bus.req_ready, m_go, m_stall);
    end
    n_checks++;
    if ({m_op, m_rm, m_rs, m_rn, m_rh} !== '0) begin
      n_fail++; $display("FAIL reset_operands: op=%h rm=%h rs=%h rn=%h rh=%h want 0",
                         m_op, m_rm, m_rs, m_rn, m_rh);
    end
    n_checks++;
    if (got_rsp() !== '0) begin
      n_fail++; $display("FAIL reset_rsp_fields: got %h want 0", got_rsp());
    end
  endtask

  task automatic test_short();
    int t, tr; bit ok, ok2; exp_t e;
    send(0, mk(OpUmlall, OpUmlall, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0), t, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL short_accept: no handshake within budget"); end
    n_checks++;
    if ({m_go, m_op, m_rm, m_rs} !== {1'b1, OpUmlall, 32'd3, 32'd5}) begin
      n_fail++; $display("FAIL short_issue: go=%b op=%h rm=%h rs=%h want 1/%h/3/5",
                         m_go, m_op, m_rm, m_rs, OpUmlall);
    end
    wait_rsp(tr, ok2);
    n_checks++;
    if (!ok2 || (tr - t) != 5) begin
      n_fail++; $display("FAIL short_latency: got %0d want 5", tr - t);
    end
    n_checks++;
    if (got_rsp() !== {1'b0, 32'd15, 32'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL short_rsp_const: got %h want lo=15 others 0", got_rsp());
    end
    e = sb.pop_front();
    n_checks++;
    if (got_rsp() !== e) begin
      n_fail++; $display("FAIL short_rsp: got %h want %h", got_rsp(), e);
    end
    n_checks++;
    if (m_go !== 1'b0) begin n_fail++; $display("FAIL short_go_in_resp: got %b want 0", m_go); end
    tick();
  endtask

  task automatic test_long();
    int t, tr, t_hi; bit ok, ok2; exp_t e;
    send(1, mk(OpUmlall, OpUmlalh, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0), t, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL long_accept: no handshake within budget"); end
    t_hi = -1; tr = -1; ok2 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (t_hi < 0 && m_op == OpUmlalh) t_hi = cyc;
      if (bus.rsp_valid) begin ok2 = 1'b1; tr = cyc; break; end
      tick();
    end
    n_checks++;
    if ((t_hi - t) != 5) begin n_fail++; $display("FAIL long_op_hi_time: got %0d want 5", t_hi - t); end
    n_checks++;
    if (!ok2 || (tr - t) != 7) begin n_fail++; $display("FAIL long_latency: got %0d want 7", tr - t); end
    n_checks++;
    if ({bus.rsp_id, bus.rsp_lo, bus.rsp_hi} !== {1'b1, 32'h0000_0001, 32'hFFFF_FFFE}) begin
      n_fail++; $display("FAIL long_halves: id=%b lo=%h hi=%h want 1/00000001/fffffffe",
                         bus.rsp_id, bus.rsp_lo, bus.rsp_hi);
    end
    e = sb.pop_front();
    n_checks++;
    if (got_rsp() !== e) begin n_fail++; $display("FAIL long_rsp: got %h want %h", got_rsp(), e); end
    tick();
  endtask

  task automatic test_back_to_back();
    req_t q0[$], q1[$];
    int   exp_gnt[4] = '{0, 1, 0, 1};
    int   ng = 0, nr = 0;
    bit   acc[2];
    exp_t e;
    q0.push_back(mk(OpUmlall, OpUmlall, 1'b0, 32'd7, 32'd9, 32'h8000_0000, 32'd0));
    q0.push_back(mk(OpUmlall, OpUmlalh, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'd11, 32'd2));
    q1.push_back(mk(OpUmlall, OpUmlalh, 1'b1, 32'hFFFF_0000, 32'h0001_0001, 32'h8000_0001, 32'd3));
    q1.push_back(mk(OpUmlall, OpUmlall, 1'b0, 32'd100, 32'd200, 32'd1, 32'd0));
    bus.req[0] = q0.pop_front();
    bus.req[1] = q1.pop_front();
    bus.req_valid = 2'b11;
    for (int i = 0; i < 80 && nr < 4; i++) begin
      #1;
      acc[0] = 1'b0; acc[1] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (bus.req_valid[p] && bus.req_ready[p]) begin
          sb.push_back(model(p[0], bus.req[p]));
          n_checks++;
          if (ng >= 4 || p != exp_gnt[ng]) begin
            n_fail++; $display("FAIL b2b_grant_order: grant #%0d got port %0d", ng, p);
          end
          ng++;
          acc[p] = 1'b1;
        end
      end
      if (bus.rsp_valid) begin
        e = sb.pop_front();
        n_checks++;
        if (got_rsp() !== e) begin
          n_fail++; $display("FAIL b2b_rsp#%0d: got %h want %h", nr, got_rsp(), e);
        end
        nr++;
      end
      tick();
      if (acc[0]) begin
        if (q0.size() > 0) bus.req[0] = q0.pop_front();
        else bus.req_valid[0] = 1'b0;
      end
      if (acc[1]) begin
        if (q1.size() > 0) bus.req[1] = q1.pop_front();
        else bus.req_valid[1] = 1'b0;
      end
    end
    bus.req_valid = 2'b00;
    n_checks++;
    if (nr != 4 || ng != 4) begin
      n_fail++; $display("FAIL b2b_count: grants=%0d rsps=%0d want 4/4", ng, nr);
    end
  endtask

  task automatic test_stall();
    int t, tr, g0; bit ok, ok2; exp_t e;
    send(0, mk(OpUmlall, OpUmlall, 1'b0, 32'd1234, 32'd77, 32'h8000_0000, 32'd5), t, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_accept: no handshake within budget"); end
    g0 = go_rises;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({m_go, m_stall, bus.rsp_valid} !== 3'b110) begin
        n_fail++; $display("FAIL stall_hold#%0d: go=%b m_stall=%b rsp_valid=%b want 1/1/0",
                           i, m_go, m_stall, bus.rsp_valid);
      end
      tick();
    end
    stall = 1'b0;
    wait_rsp(tr, ok2);
    n_checks++;
    if (!ok2 || (tr - t) != 8) begin n_fail++; $display("FAIL stall_latency: got %0d want 8", tr - t); end
    e = sb.pop_front();
    n_checks++;
    if (got_rsp() !== e) begin n_fail++; $display("FAIL stall_rsp: got %h want %h", got_rsp(), e); end
    n_checks++;
    if ((go_rises - g0) != 1) begin
      n_fail++; $display("FAIL stall_go_pulses: got %0d want 1", go_rises - g0);
    end
    tick();
    // Idle with stall: request must not be accepted.
    stall = 1'b1;
    bus.req[0] = mk(OpUmlall, OpUmlall, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0);
    bus.req_valid[0] = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b00) begin
      n_fail++; $display("FAIL stall_idle_ready: got %b want 00", bus.req_ready);
    end
    tick(); tick();
    n_checks++;
    if (m_go !== 1'b0) begin n_fail++; $display("FAIL stall_idle_accept: go=%b want 0", m_go); end
    bus.req_valid = 2'b00;
    stall = 1'b0;
  endtask

  task automatic test_clear();
    int t, tr; bit ok, ok2, seen; exp_t e;
    send(1, mk(OpUmlall, OpUmlalh, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 32'd0), t, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL clear_accept: no handshake within budget"); end
    repeat (5) tick();
    n_checks++;
    if ({m_go, m_op} !== {1'b1, OpUmlalh}) begin
      n_fail++; $display("FAIL clear_pre_state: go=%b op=%h want 1/%h", m_go, m_op, OpUmlalh);
    end
    clr = 1'b1;
    #1;
    n_checks++;
    if (m_clear !== 1'b1) begin n_fail++; $display("FAIL clear_fwd: got %b want 1", m_clear); end
    tick();
    clr = 1'b0;
    n_checks++;
    if ({bus.rsp_valid, m_go, m_op} !== '0) begin
      n_fail++; $display("FAIL clear_idle: rsp_valid=%b go=%b op=%h want 0",
                         bus.rsp_valid, m_go, m_op);
    end
    void'(sb.pop_back());
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      seen |= bus.rsp_valid;
      tick();
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL clear_no_rsp: got rsp_valid=1 want none"); end
    send(0, mk(OpUmlall, OpUmlall, 1'b0, 32'd6, 32'd7, 32'd8, 32'd0), t, ok);
    wait_rsp(tr, ok2);
    n_checks++;
    if (!ok || !ok2 || (tr - t) != 5) begin
      n_fail++; $display("FAIL clear_next_latency: got %0d want 5", tr - t);
    end
    e = sb.pop_front();
    n_checks++;
    if (got_rsp() !== e) begin n_fail++; $display("FAIL clear_next_rsp: got %h want %h", got_rsp(), e); end
    tick();
  endtask

  task automatic test_rsp_hold();
    int t, tr; bit ok, ok2; exp_t e;
    bus.rsp_ready = 1'b0;
    send(1, mk(OpUmlall, OpUmlall, 1'b0, 32'hABCD, 32'h1111, 32'h8000_0002, 32'd0), t, ok);
    wait_rsp(tr, ok2);
    n_checks++;
    if (!ok || !ok2 || (tr - t) != 5) begin
      n_fail++; $display("FAIL hold_latency: got %0d want 5", tr - t);
    end
    bus.req[0] = mk(OpUmlall, OpUmlall, 1'b0, 32'd2, 32'd2, 32'd0, 32'd0);
    bus.req[1] = mk(OpUmlall, OpUmlall, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0);
    bus.req_valid = 2'b11;
    e = sb[0];
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (!bus.rsp_valid || got_rsp() !== e || bus.req_ready !== 2'b00 || m_go !== 1'b0) begin
        n_fail++; $display("FAIL hold#%0d: valid=%b rsp=%h ready=%b go=%b want 1/%h/00/0",
                           i, bus.rsp_valid, got_rsp(), bus.req_ready, m_go, e);
      end
      tick();
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    #1;
    e = sb.pop_front();
    n_checks++;
    if (got_rsp() !== e) begin n_fail++; $display("FAIL hold_final_rsp: got %h want %h", got_rsp(), e); end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: rsp_valid=%b want 0", bus.rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_back_to_back();
    test_stall();
    test_clear();
    test_rsp_hold();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_empty: %0d entries left want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
